// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode/direction encodings and clamp helper for the counter library
package counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    localparam bit DIR_DOWN  = 1'b0;
    localparam bit DIR_UP    = 1'b1;

    function automatic logic [31:0] clamp_to_max(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - modulo-PRESCALE tick divider, one tick_out per PRESCALE tick_in cycles
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick_in,
    output logic tick_out
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_phase;
    logic          w_last;

    assign w_last   = (r_phase == LAST);
    assign tick_out = tick_in && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_phase <= '0;
        end else if (tick_in) begin
            r_phase <= w_last ? '0 : r_phase + CW'(1);
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with wrap/saturate, pulses, sticky flags, match
// Optional enable prescaler: UPDOWN_COUNTER_PRESCALE_EN
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SAT_MODE = MODE_WRAP,
    parameter int unsigned      PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic             match
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH out of range");
    end
    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
        $error("updown_mod_counter: PRESCALE out of range");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_ovf_pulse;
    logic             r_unf_pulse;
    logic             r_ovf_sticky;
    logic             r_unf_sticky;

    logic             w_step;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next_count;
    logic             w_ovf_evt;
    logic             w_unf_evt;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // A load takes priority over enable, so that cycle is not an accepted enable.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .tick_in  (enable && !load),
        .tick_out (w_step)
    );
`else
    assign w_step = enable;
`endif

    assign w_load_val = WIDTH'(clamp_to_max(32'(data_in), 32'(MAX_VAL)));

    always_comb begin
        w_next_count = r_count;
        w_ovf_evt    = 1'b0;
        w_unf_evt    = 1'b0;
        if (load) begin
            w_next_count = w_load_val;
        end else if (w_step) begin
            if (dir == DIR_UP) begin
                if (r_count >= MAX_VAL) begin
                    w_ovf_evt    = 1'b1;
                    w_next_count = (SAT_MODE == MODE_SAT) ? MAX_VAL : '0;
                end else begin
                    w_next_count = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_unf_evt    = 1'b1;
                    w_next_count = (SAT_MODE == MODE_SAT) ? '0 : MAX_VAL;
                end else begin
                    w_next_count = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_ovf_pulse  <= 1'b0;
            r_unf_pulse  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            r_count      <= w_next_count;
            r_ovf_pulse  <= w_ovf_evt;
            r_unf_pulse  <= w_unf_evt;
            // A new event in the same cycle as clr_flags keeps the flag set.
            r_ovf_sticky <= w_ovf_evt || (r_ovf_sticky && !clr_flags);
            r_unf_sticky <= w_unf_evt || (r_unf_sticky && !clr_flags);
        end
    end

    assign count      = r_count;
    assign ovf_pulse  = r_ovf_pulse;
    assign unf_pulse  = r_unf_pulse;
    assign ovf_sticky = r_ovf_sticky;
    assign unf_sticky = r_unf_sticky;
    assign match      = (r_count == cmp_val);

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised up/down modulo counter. Successor to the team's 4-bit up counter, generalised in width, terminal value and overflow handling.
- Adds direction control, wrap/saturate mode, one-cycle overflow/underflow pulses, sticky error flags and a compare-match output.
- Used as the timing/event counter primitive in the counter library.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, terminal count; counter range is 0..MAX_VAL inclusive
SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate at boundaries
PRESCALE, 4, enable-tick divider ratio (2..256); used only with the optional feature

Ports:
clk  in  1  rising-edge clock; single clock domain
rst  in  1  synchronous, active-high reset
enable  in  1  count request for this cycle
dir  in  1  1 = count up, 0 = count down
load  in  1  synchronous load of data_in
data_in  in  WIDTH  load value
cmp_val  in  WIDTH  compare value for match
clr_flags  in  1  clears sticky flags
count  out  WIDTH  current count (registered)
ovf_pulse  out  1  one-cycle pulse on up-boundary event (registered)
unf_pulse  out  1  one-cycle pulse on down-boundary event (registered)
ovf_sticky  out  1  sticky overflow flag
unf_sticky  out  1  sticky underflow flag
match  out  1  count == cmp_val (combinational from count register)

Behaviour:
- Priority, evaluated at each rising clk: rst > load > enable. All state is updated on the clock edge; reset is synchronous and active-high.
- Reset: count = 0; ovf_pulse, unf_pulse, ovf_sticky, unf_sticky all 0.
- Load: count <= min(data_in, MAX_VAL); a value above MAX_VAL is clamped. Pulses are 0 that cycle. Sticky flags are unchanged. enable is ignored.
- Enable with dir = 1:
  - count < MAX_VAL: count + 1.
  - count == MAX_VAL, wrap mode: count <= 0 and ovf_pulse = 1.
  - count == MAX_VAL, saturate mode: count holds and ovf_pulse = 1.
- Enable with dir = 0:
  - count > 0: count - 1.
  - count == 0, wrap mode: count <= MAX_VAL and unf_pulse = 1.
  - count == 0, saturate mode: count holds and unf_pulse = 1.
- Idle (no enable, no load): count holds; pulses = 0.
- Pulse timing: each pulse is high for exactly the one cycle following the boundary edge. Back-to-back boundary events give back-to-back pulses.
- Sticky flags: set by the corresponding pulse condition. clr_flags clears both. If set and clear occur in the same cycle, set wins.
- match: high whenever count == cmp_val. Valid one cycle after a load or count update, with no extra latency.
- Arithmetic: unsigned, WIDTH bits. No intermediate value may exceed MAX_VAL. Boundary compares use MAX_VAL, never 2**WIDTH-1.
- Reset mid-operation: takes effect on the next edge regardless of enable, load or clr_flags.

Optional Feature:
Macro: UPDOWN_COUNTER_PRESCALE_EN.
- Defined: enable pulses feed an internal prescaler. The counter steps once per PRESCALE accepted enable cycles.
  - The prescaler resets to 0 on rst or load.
  - dir and the boundary rules apply at the step.
- Not defined: every enable cycle steps the counter, and the PRESCALE parameter is ignored.

Decomposition:
- Package counter_pkg holds:
  - SAT_MODE encodings: MODE_WRAP = 0, MODE_SAT = 1.
  - Direction constants: DIR_DOWN = 0, DIR_UP = 1.
  - A function clamp_to_max(value, max).
- One sub-module, counter_prescaler: modulo-PRESCALE tick divider with inputs clk, rst, clr, tick_in and output tick_out. It is instantiated only under the macro.

Test Plan:
- WIDTH=4, MAX_VAL=9, wrap, enable=1, dir=1 from reset, 10 cycles -> count runs 1..9 then 0; ovf_pulse high exactly in the cycle count shows 0; ovf_sticky=1.
- Same configuration, dir=0 from count=0 -> count=9, unf_pulse one cycle, unf_sticky=1. clr_flags at the same cycle as a new underflow -> unf_sticky stays 1.
- SAT_MODE=1, MAX_VAL=9, count=9, enable, dir=1 for 3 cycles -> count stays 9 and ovf_pulse is high for 3 consecutive cycles.
- load=1 with data_in=12 (MAX_VAL=9) together with enable=1 -> count=9, no pulses, sticky flags unchanged; cmp_val=9 -> match=1.
- rst asserted mid-count (count=5, enable=1, load=1) -> next cycle count=0 and all flags 0.
- With UPDOWN_COUNTER_PRESCALE_EN and PRESCALE=4, enable held high for 12 cycles from reset -> count=3; a load at cycle 6 restarts prescale phase.
